// File: rtl/config_chain_loader_pkg.sv
// Shared types and helpers for the configuration chain loader.
package config_chain_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } loader_state_e;

    // Number of host words needed to cover the whole chain (last one may be partial).
    function automatic int unsigned words_per_chain(input int unsigned chain_length,
                                                    input int unsigned word_width);
        return (chain_length + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/config_chain_loader_readback_packer.sv
// Serial-to-parallel assembler for bits leaving the chain tail, LSB first.
module config_readback_packer
    import config_chain_loader_pkg::*;
#(
    parameter int unsigned  WORD_WIDTH = 8,
    localparam int unsigned FILL_WIDTH = $clog2(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  bit_in,
    input  logic                  flush,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  valid_out
);
    logic [WORD_WIDTH-1:0] rb_sreg_q, rb_sreg_d;
    logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
    logic [FILL_WIDTH-1:0] fill_q, fill_d;
    logic                  rb_valid_q, rb_valid_d;
    logic [WORD_WIDTH-1:0] word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_sreg_q  <= '0;
            rb_data_q  <= '0;
            fill_q     <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_sreg_q  <= rb_sreg_d;
            rb_data_q  <= rb_data_d;
            fill_q     <= fill_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    // Bits land at their final index, so a flushed partial word is already right-aligned.
    always_comb begin
        rb_sreg_d  = rb_sreg_q;
        rb_data_d  = rb_data_q;
        fill_d     = fill_q;
        rb_valid_d = 1'b0;
        word       = rb_sreg_q;
        word[fill_q] = bit_in;
        if (clear) begin
            rb_sreg_d = '0;
            fill_d    = '0;
        end else if (shift_en) begin
            if (flush || (fill_q == FILL_WIDTH'(WORD_WIDTH - 1))) begin
                rb_data_d  = word;
                rb_valid_d = 1'b1;
                rb_sreg_d  = '0;
                fill_d     = '0;
            end else begin
                rb_sreg_d = word;
                fill_d    = fill_q + FILL_WIDTH'(1);
            end
        end
    end

    assign data_out  = rb_data_q;
    assign valid_out = rb_valid_q;

endmodule

// File: rtl/config_chain_loader.sv
// Writer end of the serial configuration chain: serializes host words into the chain head
// and returns the previous chain contents as readback words.
module config_chain_loader
    import config_chain_loader_pkg::*;
#(
    parameter int unsigned  CHAIN_LENGTH = 40,
    parameter int unsigned  WORD_WIDTH   = 8,
    localparam int unsigned CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clock,
    input  logic                  config_nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  chain_data,
    output logic                  chain_enable,
    input  logic                  chain_tail,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned WB_WIDTH = $clog2(WORD_WIDTH + 1);

    loader_state_e         state_q, state_d;
    logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_WIDTH-1:0]  bit_count_q, bit_count_d;
    logic [WB_WIDTH-1:0]   word_bits_q, word_bits_d;
    int unsigned           bits_left;
    logic                  word_last;
    logic                  last_shift;

    always_ff @(posedge clock or negedge config_nreset) begin
        if (!config_nreset) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bit_count_q <= '0;
            word_bits_q <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_count_q <= bit_count_d;
            word_bits_q <= word_bits_d;
        end
    end

    always_comb begin
        bits_left  = CHAIN_LENGTH - 32'(bit_count_q);
        word_last  = (word_bits_q == WB_WIDTH'(1));
        last_shift = (state_q == ST_SHIFT) && (bits_left == 1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_FETCH;
            ST_FETCH: if (in_valid)  state_d = ST_SHIFT;
            ST_SHIFT: if (word_last) state_d = last_shift ? ST_DONE : ST_FETCH;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // The last word is clipped to the bits still missing from the chain.
    always_comb begin
        sreg_d      = sreg_q;
        bit_count_d = bit_count_q;
        word_bits_d = word_bits_q;
        case (state_q)
            ST_IDLE: if (start) bit_count_d = '0;
            ST_FETCH: if (in_valid) begin
                sreg_d      = in_data;
                word_bits_d = (bits_left >= WORD_WIDTH) ? WB_WIDTH'(WORD_WIDTH)
                                                        : WB_WIDTH'(bits_left);
            end
            ST_SHIFT: begin
                sreg_d      = sreg_q >> 1;
                bit_count_d = bit_count_q + CNT_WIDTH'(1);
                word_bits_d = word_bits_q - WB_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == ST_FETCH);
        chain_enable = (state_q == ST_SHIFT);
        chain_data   = (state_q == ST_SHIFT) && sreg_q[0];
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
    end

    config_readback_packer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_packer (
        .clk       (clock),
        .rst_n     (config_nreset),
        .clear     ((state_q == ST_IDLE) && start),
        .shift_en  (state_q == ST_SHIFT),
        .bit_in    (chain_tail),
        .flush     (last_shift),
        .data_out  (rb_data),
        .valid_out (rb_valid)
    );

endmodule

// File: tb/tb_config_chain_loader.sv
// Loopback bench: two loaders (40-bit and 10-bit chains) driving behavioural chain models.
module tb_config_chain_loader;
    import config_chain_loader_pkg::*;

    logic clock = 1'b0;
    logic config_nreset = 1'b0;
    always #5 clock = ~clock;

    logic       a_start = 1'b0, a_in_valid = 1'b0;
    logic [7:0] a_in_data = '0;
    logic       a_in_ready, a_chain_data, a_chain_enable, a_chain_tail, a_rb_valid, a_busy, a_done;
    logic [7:0] a_rb_data;
    logic       b_start = 1'b0, b_in_valid = 1'b0;
    logic [7:0] b_in_data = '0;
    logic       b_in_ready, b_chain_data, b_chain_enable, b_chain_tail, b_rb_valid, b_busy, b_done;
    logic [7:0] b_rb_data;

    config_chain_loader #(.CHAIN_LENGTH(40), .WORD_WIDTH(8)) dut_a (
        .clock(clock), .config_nreset(config_nreset), .start(a_start),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .chain_data(a_chain_data), .chain_enable(a_chain_enable), .chain_tail(a_chain_tail),
        .rb_data(a_rb_data), .rb_valid(a_rb_valid), .busy(a_busy), .done(a_done)
    );

    config_chain_loader #(.CHAIN_LENGTH(10), .WORD_WIDTH(8)) dut_b (
        .clock(clock), .config_nreset(config_nreset), .start(b_start),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .chain_data(b_chain_data), .chain_enable(b_chain_enable), .chain_tail(b_chain_tail),
        .rb_data(b_rb_data), .rb_valid(b_rb_valid), .busy(b_busy), .done(b_done)
    );

    // Chains: new bits enter at the top, the tail is bit 0 (first bit ends deepest, at bit 0).
    logic [39:0] a_chain = '0;
    logic [9:0]  b_chain = '0;
    always @(posedge clock) begin
        if (a_chain_enable) a_chain <= {a_chain_data, a_chain[39:1]};
        if (b_chain_enable) b_chain <= {b_chain_data, b_chain[9:1]};
    end
    assign a_chain_tail = a_chain[0];
    assign b_chain_tail = b_chain[0];

    int          cyc = 0;
    int          a_en_cnt = 0, a_done_cnt = 0, a_rb_cnt = 0, a_done_cyc = 0;
    int          b_en_cnt = 0, b_done_cnt = 0, b_rb_cnt = 0, b_done_cyc = 0;
    logic        b_coincide = 1'b0;
    logic [7:0]  a_rb_log [0:63];
    logic [7:0]  b_rb_log [0:63];

    always @(negedge clock) begin
        cyc++;
        if (a_chain_enable) a_en_cnt++;
        if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
        if (a_rb_valid) begin if (a_rb_cnt < 64) a_rb_log[a_rb_cnt] = a_rb_data; a_rb_cnt++; end
        if (b_chain_enable) b_en_cnt++;
        if (b_done) begin b_done_cnt++; b_done_cyc = cyc; b_coincide = b_rb_valid; end
        if (b_rb_valid) begin if (b_rb_cnt < 64) b_rb_log[b_rb_cnt] = b_rb_data; b_rb_cnt++; end
    end

    int checks = 0;
    int failures = 0;
    int en_base, done_base, rb_base, start_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic drive_start(input bit b);
        if (b) b_start = 1'b1; else a_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Present a word and return once the handshake edge has passed (first SHIFT cycle).
    task automatic send_word(input bit b, input logic [7:0] w, input string tag);
        int n = 0;
        if (b) begin b_in_data = w; b_in_valid = 1'b1; end
        else   begin a_in_data = w; a_in_valid = 1'b1; end
        while (!(b ? b_in_ready : a_in_ready) && n < 100) begin tick(); n++; end
        check({tag, "_in_ready_seen"}, b ? b_in_ready : a_in_ready, 1'b1);
        tick();
    endtask

    task automatic wait_done(input bit b, input int prev, input string tag);
        int n = 0;
        while (((b ? b_done_cnt : a_done_cnt) == prev) && n < 300) begin tick(); n++; end
        tick();
        tick();
        check({tag, "_done_once"}, (b ? b_done_cnt : a_done_cnt) - prev, 1);
    endtask

    task automatic load_a(input string tag, input logic [39:0] words, input logic [39:0] exp_chain,
                          input logic [39:0] exp_rb, input int stall, input bit poke_start);
        logic [39:0] snap_chain;
        logic [39:0] rb40;
        int          snap_en;
        int          n;
        en_base = a_en_cnt; done_base = a_done_cnt; rb_base = a_rb_cnt; start_cyc = cyc;
        drive_start(1'b0);
        check({tag, "_busy_after_start"}, a_busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_word(1'b0, words[8*i +: 8], tag);
            if (i == 0 && stall > 0) begin
                a_in_valid = 1'b0;
                n = 0;
                while (!a_in_ready && n < 100) begin tick(); n++; end
                snap_chain = a_chain;
                snap_en = a_en_cnt;
                repeat (stall) tick();
                check({tag, "_stall_no_enable"}, a_en_cnt - snap_en, 0);
                check({tag, "_stall_chain_held"}, a_chain, snap_chain);
            end
            if (i == 2 && poke_start) begin
                a_start = 1'b1;
                tick();
                a_start = 1'b0;
            end
        end
        a_in_valid = 1'b0;
        wait_done(1'b0, done_base, tag);
        check({tag, "_idle_after_done"}, a_busy, 1'b0);
        check({tag, "_chain"}, a_chain, exp_chain);
        check({tag, "_enable_cycles"}, a_en_cnt - en_base, 40);
        check({tag, "_load_time"}, a_done_cyc - start_cyc, 40 + words_per_chain(40, 8) + 1 + stall);
        check({tag, "_rb_count"}, a_rb_cnt - rb_base, 5);
        rb40 = '0;
        for (int i = 0; i < 5; i++) rb40[8*i +: 8] = a_rb_log[rb_base + i];
        check({tag, "_rb_words"}, rb40, exp_rb);
    endtask

    task automatic load_b(input string tag, input logic [15:0] words, input logic [9:0] exp_chain,
                          input logic [15:0] exp_rb);
        en_base = b_en_cnt; done_base = b_done_cnt; rb_base = b_rb_cnt; start_cyc = cyc;
        drive_start(1'b1);
        send_word(1'b1, words[7:0], tag);
        send_word(1'b1, words[15:8], tag);
        b_in_valid = 1'b0;
        wait_done(1'b1, done_base, tag);
        check({tag, "_chain"}, b_chain, exp_chain);
        check({tag, "_enable_cycles"}, b_en_cnt - en_base, 10);
        check({tag, "_load_time"}, b_done_cyc - start_cyc, 10 + words_per_chain(10, 8) + 1);
        check({tag, "_rb_count"}, b_rb_cnt - rb_base, 2);
        check({tag, "_rb_word0"}, b_rb_log[rb_base], exp_rb[7:0]);
        check({tag, "_rb_word1_partial"}, b_rb_log[rb_base + 1], exp_rb[15:8]);
        check({tag, "_rb_with_done"}, b_coincide, 1'b1);
    endtask

    initial begin
        config_nreset = 1'b0;
        repeat (3) tick();
        check("reset_outputs_a", {a_in_ready, a_chain_enable, a_chain_data, a_busy, a_done,
                                  a_rb_valid, a_rb_data}, '0);
        check("reset_outputs_b", {b_in_ready, b_chain_enable, b_chain_data, b_busy, b_done,
                                  b_rb_valid, b_rb_data}, '0);
        config_nreset = 1'b1;
        tick();

        load_a("load1", 40'h8967452301, 40'h8967452301, 40'h0000000000, 0, 1'b0);
        load_a("load_ff", 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'h8967452301, 0, 1'b0);
        load_a("stall", 40'h8967452301, 40'h8967452301, 40'hFFFFFFFFFF, 7, 1'b0);

        // Abort a load in its third SHIFT cycle; two bits (1 then 0) have entered the chain.
        drive_start(1'b0);
        send_word(1'b0, 8'h01, "abort");
        tick();
        tick();
        check("abort_in_shift", a_chain_enable, 1'b1);
        a_in_valid = 1'b0;
        #2 config_nreset = 1'b0;
        #1;
        check("abort_enable_low", a_chain_enable, 1'b0);
        check("abort_busy_low", a_busy, 1'b0);
        check("abort_ready_low", a_in_ready, 1'b0);
        check("abort_partial_chain", a_chain, 40'h6259D148C0);
        tick();
        tick();
        config_nreset = 1'b1;
        tick();
        check("abort_rb_data_cleared", a_rb_data, 8'h00);

        load_a("fresh_poke", 40'h8967452301, 40'h8967452301, 40'h6259D148C0, 0, 1'b1);

        load_b("short1", 16'hFEA5, 10'h2A5, 16'h0000);
        load_b("short2", 16'h0000, 10'h000, 16'h02A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
